bsg_channel_widen: RTL and testbench
====================================

Name: bsg_channel_widen

Overview:
- Inverse of the channel narrowing stage. Accepts a stream of width_in_p-bit slices and assembles each group of els_lp = width_out_p/width_in_p consecutive slices into one width_out_p-bit word.
- Sits at the receive end of a narrowed link and rebuilds the original wide word before handing it to wide-datapath logic.
- Input side uses a valid/ready handshake; output side uses a valid/yumi handshake.

Parameters:
- width_in_p, 8, narrow slice width in bits.
- width_out_p, 16, assembled word width in bits. Must be an integer multiple of width_in_p with ratio >= 2; any other value is an elaboration error.
- lsb_first_p, 1, slice ordering. 1: first slice lands in bits [width_in_p-1:0]. 0: first slice lands in the top slice position.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- v_i  input  1  narrow slice valid.
- data_i  input  width_in_p  narrow slice data.
- ready_o  output  1  block accepts a slice this cycle. A slice transfers when v_i & ready_o.
- v_o  output  1  assembled word valid.
- data_o  output  width_out_p  assembled word.
- yumi_i  input  1  consumer takes the word this cycle. Legal only when v_o=1.

Behaviour:
- Reset (reset_n_i=0, asynchronous assert, synchronous release):
  - cnt_r=0, full_r=0, data buffer = 0.
  - v_o=0, data_o=0, ready_o=1.
- State is a slice counter cnt_r (0..els_lp-1) plus a full_r flag. Effective states:
  - FILLING: full_r=0.
  - FULL: full_r=1; cnt_r is 0 in this state.
- ready_o = ~full_r | yumi_i. This is combinational from yumi_i; there is no combinational path from v_i to ready_o.
- On slice accept:
  - Slice written to position p, where p = cnt_r if lsb_first_p=1, else els_lp-1-cnt_r. Position p covers bits [p*width_in_p +: width_in_p].
  - cnt_r increments. When cnt_r=els_lp-1, cnt_r wraps to 0 and full_r sets.
- v_o = full_r; data_o = data buffer.
  - Latency: v_o rises the cycle after the last slice is accepted.
  - data_o is stable for as long as v_o=1 and yumi_i=0.
- On yumi_i=1: full_r clears, unless the same cycle also accepts a final slice.
  - When els_lp>=2 a final slice cannot arrive in that cycle, so full_r always clears.
- Simultaneous yumi_i and slice accept while FULL: the slice is written as slice 0 of the next word and cnt_r becomes 1. The old word is considered consumed at that edge.
- Throughput: one slice per cycle sustained with no bubbles while the consumer yumis the same cycle v_o is high.
- Upstream stall: when v_i=0, cnt_r and the buffer hold. Partial words persist indefinitely.
- yumi_i=1 while v_o=0 is illegal; the block ignores it and state is unchanged.
- Reset mid-word discards the partial word: cnt_r returns to 0 and the buffer clears.
- Buffer slices not yet written for the current word hold stale data. data_o is meaningful only while v_o=1.

Optional Feature:
- Macro: BSG_CHANNEL_WIDEN_FLUSH_EN.
- Defined: adds input port flush_i (1 bit).
  - If flush_i=1 in FILLING with cnt_r>0 (counting a slice accepted that same cycle), the word completes at that edge. All not-yet-written slice positions are zero-filled, full_r sets, and cnt_r returns to 0.
  - flush_i is ignored in FULL and when cnt_r=0 with no slice accepted.
  - A slice accepted in the flush cycle is included in the word.
- Undefined: no flush_i port. Words complete only after els_lp slices.

Test Plan:
- Reset: hold reset_n_i=0 -> v_o=0, ready_o=1, data_o=16'h0000. Release, drive 0x34 for one cycle, then v_i=0 -> v_o stays 0 and cnt_r=1.
- Basic assembly (lsb_first_p=1): slices 0x34 then 0x12 on consecutive cycles -> next cycle v_o=1, data_o=16'h1234.
- Backpressure: word 0x1234 held with yumi_i=0 for 5 cycles and v_i=1 with 0x56 -> ready_o=0, data_o stays 16'h1234, no slice accepted. yumi_i=1 -> 0x56 accepted the same cycle.
- Streaming: slices 0x01,0x02,0x03,0x04 back-to-back, with yumi_i asserted whenever v_o=1 -> words 16'h0201 then 16'h0403, no stall cycles.
- Ordering (lsb_first_p=0): slices 0xAB then 0xCD -> data_o=16'hABCD.
- Reset mid-word, plus flush (with BSG_CHANNEL_WIDEN_FLUSH_EN):
  - Accept 0x77, pulse reset_n_i low, then accept 0x11, 0x22 -> data_o=16'h2211.
  - Accept 0x5A with flush_i=1 in the same cycle -> v_o=1, data_o=16'h005A.

Source files
------------

// File: rtl/bsg_channel_widen.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_channel_widen
//  Purpose  : Assembles groups of width_out_p/width_in_p narrow slices into one
//             wide word. Valid/ready on the slice side, valid/yumi on the word
//             side. Optional flush support under BSG_CHANNEL_WIDEN_FLUSH_EN
//             adds flush_i, which completes a partial word by zero-filling the
//             slice positions that have not been written.
//  Revision : 1.0  initial release
// ============================================================================
module bsg_channel_widen #(
   parameter int width_in_p  = 8,
   parameter int width_out_p = 16,
   parameter bit lsb_first_p = 1'b1
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   v_i,
   input  logic [width_in_p-1:0]  data_i,
   output logic                   ready_o,
   output logic                   v_o,
   output logic [width_out_p-1:0] data_o,
`ifdef BSG_CHANNEL_WIDEN_FLUSH_EN
   input  logic                   flush_i,
`endif
   input  logic                   yumi_i
);

   localparam int c_ELS   = width_out_p / width_in_p;
   localparam int c_CNT_W = (c_ELS > 2) ? $clog2(c_ELS) : 1;

   // The output word must be an exact multiple (at least two) of the slice.
   if ((width_out_p % width_in_p != 0) || (c_ELS < 2)) begin : g_bad_ratio
      $error("bsg_channel_widen: width_out_p must be a multiple >= 2 of width_in_p");
   end

   // Slice index k of a word lands in this slice position of the buffer.
   function automatic int f_pos(input int k);
      f_pos = lsb_first_p ? k : (c_ELS - 1 - k);
   endfunction

   logic [c_CNT_W-1:0]     r_cnt;
   logic                   r_full;
   logic [width_out_p-1:0] r_data;

   logic [c_CNT_W-1:0]     w_cnt_nxt;
   logic                   w_full_nxt;
   logic [width_out_p-1:0] w_data_nxt;

   logic                   w_accept;
   logic                   w_yumi;
   logic                   w_last;
   logic                   w_flush_fire;
   logic [c_CNT_W:0]       w_n_written;

   // yumi is only meaningful while a word is held; otherwise it is ignored.
   assign w_accept    = v_i & ready_o;
   assign w_yumi      = yumi_i & r_full;
   assign w_last      = (r_cnt == c_CNT_W'(c_ELS - 1));
   assign w_n_written = {1'b0, r_cnt} + {{c_CNT_W{1'b0}}, w_accept};

`ifdef BSG_CHANNEL_WIDEN_FLUSH_EN
   // Flush closes a non-empty partial word; it has no effect on a full buffer.
   assign w_flush_fire = flush_i & ~r_full & (w_n_written != '0);
`else
   assign w_flush_fire = 1'b0;
`endif

   // State register: slice counter, full flag and assembly buffer.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_cnt  <= '0;
         r_full <= 1'b0;
         r_data <= '0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_full <= w_full_nxt;
         r_data <= w_data_nxt;
      end
   end

   // Next-state: consume on yumi, then place an accepted slice, then flush.
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_full_nxt = r_full;
      w_data_nxt = r_data;

      if (w_yumi) begin
         w_full_nxt = 1'b0;
      end

      if (w_accept) begin
         for (int k = 0; k < c_ELS; k++) begin
            if (r_cnt == c_CNT_W'(k)) begin
               w_data_nxt[f_pos(k)*width_in_p +: width_in_p] = data_i;
            end
         end
         if (w_last) begin
            w_cnt_nxt  = '0;
            w_full_nxt = 1'b1;
         end else begin
            w_cnt_nxt  = r_cnt + c_CNT_W'(1);
         end
      end

      // Positions beyond the slices written so far are zeroed on flush.
      if (w_flush_fire) begin
         for (int k = 0; k < c_ELS; k++) begin
            if ((c_CNT_W+1)'(k) >= w_n_written) begin
               w_data_nxt[f_pos(k)*width_in_p +: width_in_p] = '0;
            end
         end
         w_cnt_nxt  = '0;
         w_full_nxt = 1'b1;
      end
   end

   // Outputs: the word is presented straight from the buffer while full;
   // a yumi frees the buffer in the same cycle so the next slice can enter.
   always_comb begin
      v_o     = r_full;
      data_o  = r_data;
      ready_o = ~r_full | yumi_i;
   end

endmodule
`default_nettype wire

// File: tb/tb_bsg_channel_widen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bsg_channel_widen
//  Purpose  : Directed bench for bsg_channel_widen. Two instances (LSB-first
//             and MSB-first) share one stimulus stream; a queue-based word
//             model is compared against both every cycle, and literal values
//             pin the model. Flush cases are built when
//             BSG_CHANNEL_WIDEN_FLUSH_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bsg_channel_widen;

   localparam int WI  = 8;
   localparam int WO  = 16;
   localparam int ELS = WO / WI;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          v_i = 1'b0;
   logic [WI-1:0] data_i = '0;
   logic          yumi_i = 1'b0;
   logic          flush_i = 1'b0;

   logic          ready_l, v_l, ready_m, v_m;
   logic [WO-1:0] data_l, data_m;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   bsg_channel_widen #(.width_in_p(WI), .width_out_p(WO), .lsb_first_p(1'b1)) u_lsb (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .data_i(data_i),
      .ready_o(ready_l), .v_o(v_l), .data_o(data_l),
`ifdef BSG_CHANNEL_WIDEN_FLUSH_EN
      .flush_i(flush_i),
`endif
      .yumi_i(yumi_i)
   );

   bsg_channel_widen #(.width_in_p(WI), .width_out_p(WO), .lsb_first_p(1'b0)) u_msb (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .data_i(data_i),
      .ready_o(ready_m), .v_o(v_m), .data_o(data_m),
`ifdef BSG_CHANNEL_WIDEN_FLUSH_EN
      .flush_i(flush_i),
`endif
      .yumi_i(yumi_i)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: list of slices -> word ----------------
   logic [WI-1:0] m_sl[$];
   bit            m_full   = 1'b0;
   logic [WO-1:0] m_word_l = '0;
   logic [WO-1:0] m_word_m = '0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_sl.delete();
         m_full   = 1'b0;
         m_word_l = '0;
         m_word_m = '0;
      end else begin
         bit was_full, acc, close;
         was_full = m_full;
         acc      = v_i && (!m_full || yumi_i);
         if (yumi_i && m_full) m_full = 1'b0;
         if (acc) m_sl.push_back(data_i);
         close = (m_sl.size() == ELS);
`ifdef BSG_CHANNEL_WIDEN_FLUSH_EN
         if (flush_i && !was_full && m_sl.size() > 0) close = 1'b1;
`endif
         if (close) begin
            m_word_l = '0;
            m_word_m = '0;
            for (int i = 0; i < m_sl.size(); i++) begin
               m_word_l[i*WI +: WI]           = m_sl[i];
               m_word_m[(ELS-1-i)*WI +: WI]   = m_sl[i];
            end
            m_sl.delete();
            m_full = 1'b1;
         end
      end
   end

   // ---------------- per-cycle compare against the model ----------------
   bit cmp_en = 1'b0;
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("v_lsb",     {31'b0, v_l},     {31'b0, m_full});
         chk("v_msb",     {31'b0, v_m},     {31'b0, m_full});
         chk("ready_lsb", {31'b0, ready_l}, {31'b0, (!m_full || yumi_i)});
         chk("ready_msb", {31'b0, ready_m}, {31'b0, (!m_full || yumi_i)});
         if (m_full) begin
            chk("data_lsb", {16'b0, data_l}, {16'b0, m_word_l});
            chk("data_msb", {16'b0, data_m}, {16'b0, m_word_m});
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_in(input logic v, input logic [WI-1:0] d, input logic y, input logic f);
      v_i = v; data_i = d; yumi_i = y; flush_i = f;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic v, input logic [WI-1:0] d, input logic y);
      set_in(v, d, y, 1'b0);
      tick();
   endtask

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_v",     {31'b0, v_l},     32'd0);
      chk("rst_ready", {31'b0, ready_l}, 32'd1);
      chk("rst_data",  {16'b0, data_l},  32'h0000);
      chk("rst_data_m",{16'b0, data_m},  32'h0000);
      @(posedge clk); #1;
      reset_n = 1'b1;
      cmp_en  = 1'b1;

      // One slice then an upstream stall: partial word persists
      cyc(1'b1, 8'h34, 1'b0);
      repeat (3) cyc(1'b0, 8'h00, 1'b0);
      chk("partial_no_v", {31'b0, v_l}, 32'd0);

      // Completing slice: word appears the next cycle
      cyc(1'b1, 8'h12, 1'b0);
      chk("basic_v",    {31'b0, v_l},    32'd1);
      chk("basic_lsb",  {16'b0, data_l}, 32'h1234);
      chk("basic_msb",  {16'b0, data_m}, 32'h3412);

      // Backpressure: full, no yumi, slice waiting
      set_in(1'b1, 8'h56, 1'b0, 1'b0);
      #1 chk("bp_ready", {31'b0, ready_l}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold", {16'b0, data_l}, 32'h1234);
      end
      set_in(1'b1, 8'h56, 1'b1, 1'b0);
      #1 chk("bp_yumi_ready", {31'b0, ready_l}, 32'd1);
      tick();
      chk("bp_after_yumi_v", {31'b0, v_l}, 32'd0);
      cyc(1'b1, 8'h78, 1'b0);
      chk("bp_next_word", {16'b0, data_l}, 32'h7856);
      cyc(1'b0, 8'h00, 1'b1);

      // Streaming with same-cycle yumi
      cyc(1'b1, 8'h01, v_l);
      cyc(1'b1, 8'h02, v_l);
      chk("stream_w0", {16'b0, data_l}, 32'h0201);
      set_in(1'b1, 8'h03, 1'b1, 1'b0);
      #1 chk("stream_ready", {31'b0, ready_l}, 32'd1);
      tick();
      chk("stream_gap_v", {31'b0, v_l}, 32'd0);
      cyc(1'b1, 8'h04, 1'b0);
      chk("stream_w1", {16'b0, data_l}, 32'h0403);
      cyc(1'b0, 8'h00, 1'b1);

      // MSB-first ordering
      cyc(1'b1, 8'hAB, 1'b0);
      cyc(1'b1, 8'hCD, 1'b0);
      chk("order_msb", {16'b0, data_m}, 32'hABCD);
      chk("order_lsb", {16'b0, data_l}, 32'hCDAB);
      cyc(1'b0, 8'h00, 1'b1);

      // Stray yumi while empty is ignored
      cyc(1'b1, 8'h99, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      cyc(1'b1, 8'h88, 1'b0);
      chk("stray_yumi", {16'b0, data_l}, 32'h8899);
      cyc(1'b0, 8'h00, 1'b1);

      // Reset mid-word discards the partial slice
      cyc(1'b1, 8'h77, 1'b0);
      set_in(1'b0, 8'h00, 1'b0, 1'b0);
      reset_n = 1'b0;
      tick();
      chk("midrst_v", {31'b0, v_l}, 32'd0);
      reset_n = 1'b1;
      cyc(1'b1, 8'h11, 1'b0);
      cyc(1'b1, 8'h22, 1'b0);
      chk("midrst_word", {16'b0, data_l}, 32'h2211);
      cyc(1'b0, 8'h00, 1'b1);

`ifdef BSG_CHANNEL_WIDEN_FLUSH_EN
      // Flush with a slice accepted the same cycle
      set_in(1'b1, 8'h5A, 1'b0, 1'b1);
      tick();
      chk("flush_v",   {31'b0, v_l},    32'd1);
      chk("flush_lsb", {16'b0, data_l}, 32'h005A);
      chk("flush_msb", {16'b0, data_m}, 32'h5A00);
      // Flush while full is ignored
      cyc(1'b0, 8'h00, 1'b0);
      set_in(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      chk("flush_full_hold", {16'b0, data_l}, 32'h005A);
      cyc(1'b0, 8'h00, 1'b1);
      // Flush with empty buffer and no slice does nothing
      set_in(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      chk("flush_empty", {31'b0, v_l}, 32'd0);
      set_in(1'b0, 8'h00, 1'b0, 1'b0);
`endif

      repeat (3) cyc(1'b0, 8'h00, 1'b0);
      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
